// File: rtl/mem_port_arbiter.sv
// Shares one single-ported data memory between instruction fetch and the MEM stage.
// MEM stage has fixed priority; a starvation counter forces a fetch grant after STARVE_LIMIT denials.
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_stall,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic [31:0] data_addr,
  input  logic        data_we,
  input  logic        data_half,
  input  logic        data_byte,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_stall,
  output logic        data_done,
  output logic [31:0] data_rdata,
  output logic [31:0] mem_addr,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_half,
  output logic        mem_byte,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    INST    = 2'd1,
    DATA_RD = 2'd2,
    DATA_WR = 2'd3
  } owner_t;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  owner_t           state;
  logic [CNT_W-1:0] starve_cnt;
  logic             fetch_win;
  logic             data_win;

  // Winner selection; reset suppresses every grant so no access reaches memory.
  always_comb begin
    fetch_win = 1'b0;
    data_win  = 1'b0;
    if (!rst) begin
      if (data_req && inst_req) begin
        if (starve_cnt >= LIMIT) fetch_win = 1'b1;
        else                     data_win  = 1'b1;
      end else if (data_req) begin
        data_win = 1'b1;
      end else if (inst_req) begin
        fetch_win = 1'b1;
      end
    end
  end

  assign inst_gnt   = fetch_win;
  assign data_gnt   = data_win;
  assign inst_stall = inst_req & ~fetch_win & ~rst;
  assign data_stall = data_req & ~data_win & ~rst;

  always_comb begin
    mem_addr  = 32'd0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_half  = 1'b0;
    mem_byte  = 1'b0;
    mem_wdata = 32'd0;
    if (fetch_win) begin
      mem_addr = inst_addr;
      mem_read = 1'b1;
    end else if (data_win) begin
      mem_addr  = data_addr;
      mem_read  = ~data_we;
      mem_write = data_we;
      mem_half  = data_half;
      mem_byte  = data_byte;
      mem_wdata = data_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!inst_req || fetch_win) begin
      starve_cnt <= '0;
    end else if (data_win && starve_cnt < LIMIT) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Owner of the access in flight; it decides where next cycle's read data goes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else if (fetch_win) begin
      state <= INST;
    end else if (data_win) begin
      state <= data_we ? DATA_WR : DATA_RD;
    end else begin
      state <= IDLE;
    end
  end

  always_comb begin
    inst_rvalid = 1'b0;
    inst_rdata  = 32'd0;
    data_done   = 1'b0;
    data_rdata  = 32'd0;
    if (!rst) begin
      case (state)
        INST: begin
          inst_rvalid = 1'b1;
          inst_rdata  = mem_rdata;
        end
        DATA_RD: begin
          data_done  = 1'b1;
          data_rdata = mem_rdata;
        end
        DATA_WR: data_done = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
